// File: rtl/gpio_filter_pkg.sv
// Shared defaults for the GPIO input conditioning slice.
package gpio_filter_pkg;

  localparam int unsigned GpioCountDefault = 32;
  localparam int unsigned CntWidthDefault  = 4;

endpackage

// File: rtl/gpio_filter_bit.sv
// One GPIO input channel: 2-FF synchronizer, glitch filter, edge pulses and sticky irq flag.
module gpio_filter_bit
  import gpio_filter_pkg::*;
#(
  parameter int unsigned CntWidth = CntWidthDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pad_i,
  input  logic [CntWidth-1:0] filter_len_i,
  input  logic                irq_en_rise_i,
  input  logic                irq_en_fall_i,
  input  logic                irq_clr_i,
  output logic                level_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                pending_o
);

  logic                sync1_q, sync2_q;
  logic                stable_q, stable_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                pending_q, pending_d;
  logic                irq_set;

  // Pure flop-to-flop synchronizer; pad_i is asynchronous to clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept only after filter_len_i+1 consecutive differing cycles; the
  // increment is gated by cnt_q < filter_len_i, so the counter cannot wrap.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= filter_len_i) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Set takes priority over a same-cycle clear.
  assign irq_set = (rise_q & irq_en_rise_i) | (fall_q & irq_en_fall_i);

  always_comb begin
    pending_d = pending_q;
    if (irq_set) begin
      pending_d = 1'b1;
    end else if (irq_clr_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  assign level_o   = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO pad input conditioning: per-bit filter channels plus a combined interrupt line.
module gpio_in_filter
  import gpio_filter_pkg::*;
#(
  parameter int unsigned GpioCount = GpioCountDefault,
  parameter int unsigned CntWidth  = CntWidthDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [GpioCount-1:0] pad_gpio_i,
  input  logic [CntWidth-1:0]  filter_len_i,
  input  logic [GpioCount-1:0] irq_en_rise_i,
  input  logic [GpioCount-1:0] irq_en_fall_i,
  input  logic [GpioCount-1:0] irq_clr_i,
  output logic [GpioCount-1:0] gpio_o,
  output logic [GpioCount-1:0] rise_o,
  output logic [GpioCount-1:0] fall_o,
  output logic [GpioCount-1:0] irq_pending_o,
  output logic                 irq_o
);

  for (genvar i = 0; i < GpioCount; i++) begin : g_bit
    gpio_filter_bit #(
      .CntWidth (CntWidth)
    ) u_bit (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .pad_i         (pad_gpio_i[i]),
      .filter_len_i  (filter_len_i),
      .irq_en_rise_i (irq_en_rise_i[i]),
      .irq_en_fall_i (irq_en_fall_i[i]),
      .irq_clr_i     (irq_clr_i[i]),
      .level_o       (gpio_o[i]),
      .rise_o        (rise_o[i]),
      .fall_o        (fall_o[i]),
      .pending_o     (irq_pending_o[i])
    );
  end

  assign irq_o = |irq_pending_o;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: reset, glitch rejection, latency, interrupts, mid-count events.
module tb_gpio_in_filter;

  logic        clk;
  logic        rst_ni;
  logic [31:0] pad_gpio;
  logic [3:0]  filter_len;
  logic [31:0] irq_en_rise;
  logic [31:0] irq_en_fall;
  logic [31:0] irq_clr;
  logic [31:0] gpio;
  logic [31:0] rise;
  logic [31:0] fall;
  logic [31:0] irq_pending;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpio_in_filter dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .pad_gpio_i    (pad_gpio),
    .filter_len_i  (filter_len),
    .irq_en_rise_i (irq_en_rise),
    .irq_en_fall_i (irq_en_fall),
    .irq_clr_i     (irq_clr),
    .gpio_o        (gpio),
    .rise_o        (rise),
    .fall_o        (fall),
    .irq_pending_o (irq_pending),
    .irq_o         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After return, outputs reflect the edge just taken; inputs set now are seen next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  logic exp_lvl, prev_lvl, pad7;

  initial begin
    rst_ni      = 1'b0;
    pad_gpio    = 32'hFFFF_FFFF;
    filter_len  = 4'd3;
    irq_en_rise = '0;
    irq_en_fall = '0;
    irq_clr     = '0;

    // 1. Reset with pad held high, L=3: rise lands at edge 5 after release.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_gpio", gpio, 32'h0);
      chk("rst_rise", rise, 32'h0);
      chk("rst_pend", irq_pending, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
    end
    rst_ni = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      chk($sformatf("rel_gpio_e%0d", k), gpio, (k >= 5) ? 32'hFFFF_FFFF : 32'h0);
      chk($sformatf("rel_rise_e%0d", k), rise, (k == 5) ? 32'hFFFF_FFFF : 32'h0);
      chk($sformatf("rel_irq_e%0d", k), {31'b0, irq}, 32'h0);
    end
    pad_gpio = '0;
    for (int k = 0; k < 8; k++) step();
    chk("idle_gpio", gpio, 32'h0);
    chk("idle_fall", fall, 32'h0);
    chk("idle_pend", irq_pending, 32'h0);

    // 2a. L=3, 3-cycle pulse on bit 0: fully rejected.
    pad_gpio = 32'h1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("glitch3_gpio_k%0d", k), gpio, 32'h0);
      chk($sformatf("glitch3_rise_k%0d", k), rise, 32'h0);
      if (k == 2) pad_gpio = 32'h0;
    end
    // 2b. 4-cycle pulse: accepted at n+5, released at n+9.
    pad_gpio = 32'h1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("pulse4_gpio_k%0d", k), gpio, (k >= 5 && k <= 8) ? 32'h1 : 32'h0);
      chk($sformatf("pulse4_rise_k%0d", k), rise, (k == 5) ? 32'h1 : 32'h0);
      chk($sformatf("pulse4_fall_k%0d", k), fall, (k == 9) ? 32'h1 : 32'h0);
      if (k == 3) pad_gpio = 32'h0;
    end

    // 3. L=0, bit 7 toggled every 4 cycles: output is the pad delayed by 2 edges.
    filter_len = 4'd0;
    pad_gpio   = 32'h80;
    prev_lvl   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_lvl = (k >= 2) ? (((k - 2) / 4) % 2 == 0) : 1'b0;
      chk($sformatf("byp_gpio_k%0d", k), gpio, {24'b0, exp_lvl, 7'b0});
      chk($sformatf("byp_rise_k%0d", k), rise, {24'b0, exp_lvl & ~prev_lvl, 7'b0});
      chk($sformatf("byp_fall_k%0d", k), fall, {24'b0, ~exp_lvl & prev_lvl, 7'b0});
      chk($sformatf("byp_ovl_k%0d", k), rise & fall, 32'h0);
      prev_lvl = exp_lvl;
      pad7 = (((k + 1) / 4) % 2 == 0);
      pad_gpio = {24'b0, pad7, 7'b0};
    end
    pad_gpio = '0;
    for (int k = 0; k < 4; k++) step();

    // 4. Falling-edge interrupt on bit 3.
    irq_en_fall = 32'h8;
    pad_gpio    = 32'h8;
    for (int k = 0; k < 5; k++) step();
    chk("irq_hi_gpio", gpio, 32'h8);
    chk("irq_rise_noset", irq_pending, 32'h0);
    pad_gpio = 32'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("irq_fall_k%0d", k), {31'b0, fall[3]}, (k == 2) ? 32'h1 : 32'h0);
      chk($sformatf("irq_pend_k%0d", k), irq_pending, (k >= 3) ? 32'h8 : 32'h0);
      chk($sformatf("irq_or_k%0d", k), {31'b0, irq}, (k >= 3) ? 32'h1 : 32'h0);
    end
    irq_clr = 32'h8;
    step();
    irq_clr = 32'h0;
    chk("irq_clr_pend", irq_pending, 32'h0);
    chk("irq_clr_or", {31'b0, irq}, 32'h0);
    step();
    chk("irq_clr_hold", irq_pending, 32'h0);
    // Clear in the same cycle as set: set wins.
    pad_gpio = 32'h8;
    for (int k = 0; k < 5; k++) step();
    pad_gpio = 32'h0;
    for (int k = 0; k < 3; k++) step();
    chk("irq_race_fall", fall, 32'h8);
    irq_clr = 32'h8;
    step();
    irq_clr = 32'h0;
    chk("irq_race_pend", irq_pending, 32'h8);
    // Dropping the enable leaves the flag pending.
    irq_en_fall = 32'h0;
    step();
    chk("irq_dis_keep", irq_pending, 32'h8);
    irq_clr = 32'h8;
    step();
    irq_clr = 32'h0;
    chk("irq_final_clr", irq_pending, 32'h0);

    // 5a. L=15 -> 2 while the counter sits at 10: accept on the next differing edge.
    filter_len = 4'd15;
    pad_gpio   = 32'h2;
    for (int k = 0; k <= 12; k++) begin
      step();
      chk($sformatf("lchg_gpio_k%0d", k), gpio, (k >= 12) ? 32'h2 : 32'h0);
      chk($sformatf("lchg_rise_k%0d", k), rise, (k == 12) ? 32'h2 : 32'h0);
      if (k == 11) filter_len = 4'd2;
    end

    // 5b. Async reset between edges with bit 2 mid-count; fresh L+1 count afterwards.
    filter_len = 4'd3;
    pad_gpio   = 32'h6;
    for (int k = 0; k < 4; k++) step();
    chk("arst_pre_gpio", gpio, 32'h2);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_gpio", gpio, 32'h0);
    chk("arst_rise", rise, 32'h0);
    chk("arst_fall", fall, 32'h0);
    chk("arst_pend", irq_pending, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    #2 rst_ni = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      chk($sformatf("arst_rel_gpio_e%0d", k), gpio, (k >= 5) ? 32'h6 : 32'h0);
      chk($sformatf("arst_rel_rise_e%0d", k), rise, (k == 5) ? 32'h6 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
